// File: rtl/sram_serial_reader_pkg.sv
// Shared definitions for the SRAM serial read-back path: default widths,
// FSM state encoding and the idle level of the SRAM control strobes.
package qd2_pkg;

   localparam int DEF_ADDR_W = 21;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   // Inactive (high) level for the active-low SRAM strobes.
   localparam logic SRAM_CTRL_IDLE = 1'b1;

endpackage

// File: rtl/sram_serial_reader_if.sv
// AVR-side and SRAM-side signal bundle of the serial reader.
// The master modport is the AVR/SRAM environment, the slave is the reader.
interface sram_serial_reader_if
   import qd2_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic [ADDR_W-1:0] start_addr;
   logic              load;
   logic              rd_req;
   logic              shift_en;
   logic [DATA_W-1:0] sram_data;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_oe_n;
   logic              sram_ce_n;
   logic              avr_so;
   logic              busy;
   logic              byte_done;

   modport master (
      output start_addr, load, rd_req, shift_en, sram_data,
      input  sram_addr, sram_oe_n, sram_ce_n, avr_so, busy, byte_done
   );

   modport slave (
      input  start_addr, load, rd_req, shift_en, sram_data,
      output sram_addr, sram_oe_n, sram_ce_n, avr_so, busy, byte_done
   );
endinterface

// File: rtl/sram_serial_reader_piso_shift.sv
// Parallel-in/serial-out register: MSB is presented first, zero fill on shift.
// `last` flags that the next shift moves out the final bit of the byte.
module piso_shift #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              so,
   output logic              last
);
   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] sreg_r;
   logic [CNT_W-1:0]  bit_cnt_r;

   // Shift register and bit counter; load restarts the count for a new byte.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sreg_r    <= {DATA_W{1'b0}};
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         sreg_r    <= din;
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (shift) begin
         sreg_r    <= {sreg_r[DATA_W-2:0], 1'b0};
         bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else begin
         sreg_r    <= sreg_r;
         bit_cnt_r <= bit_cnt_r;
      end
   end

   assign so   = sreg_r[DATA_W-1];
   assign last = (bit_cnt_r == CNT_W'(DATA_W - 1));
endmodule

// File: rtl/sram_serial_reader.sv
// Fetches one SRAM byte per request and shifts it to the AVR MSB-first,
// auto-incrementing the SRAM address after each completed byte.
module sram_serial_reader
   import qd2_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                 avr_clk,
   input  logic                 avr_reset,
   sram_serial_reader_if.slave  bus
);
   localparam int WAIT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACCESS_CYCLES - 1);

   state_t            state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              oe_n_r;
   logic              ce_n_r;
   logic              busy_r;
   logic              byte_done_r;
   logic              capture_s;
   logic              shift_s;
   logic              last_s;
   logic              so_s;

   // The wait count only runs once the strobes are already low, so data is
   // sampled after exactly ACCESS_CYCLES cycles of active oe_n/ce_n.
   assign capture_s = (state_r == ST_READ) && !oe_n_r && (wait_cnt_r == WAIT_LAST) && !bus.load;
   assign shift_s   = (state_r == ST_SHIFT) && bus.shift_en && !bus.load;

   piso_shift #(.DATA_W(DATA_W)) u_piso (
      .clk   (avr_clk),
      .rst   (avr_reset),
      .clr   (bus.load),
      .load  (capture_s),
      .shift (shift_s),
      .din   (bus.sram_data),
      .so    (so_s),
      .last  (last_s)
   );

   // Read FSM with wait counter, address counter and registered strobes.
   always_ff @(posedge avr_clk) begin
      if (avr_reset) begin
         state_r     <= ST_IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         wait_cnt_r  <= {WAIT_W{1'b0}};
         oe_n_r      <= SRAM_CTRL_IDLE;
         ce_n_r      <= SRAM_CTRL_IDLE;
         busy_r      <= 1'b0;
         byte_done_r <= 1'b0;
      end else if (bus.load) begin
         state_r     <= ST_IDLE;
         addr_r      <= bus.start_addr;
         wait_cnt_r  <= {WAIT_W{1'b0}};
         oe_n_r      <= SRAM_CTRL_IDLE;
         ce_n_r      <= SRAM_CTRL_IDLE;
         busy_r      <= 1'b0;
         byte_done_r <= 1'b0;
      end else begin
         byte_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.rd_req) begin
                  state_r    <= ST_READ;
                  busy_r     <= 1'b1;
                  wait_cnt_r <= {WAIT_W{1'b0}};
               end else begin
                  busy_r     <= 1'b0;
               end
            end
            ST_READ: begin
               if (oe_n_r) begin
                  oe_n_r     <= 1'b0;
                  ce_n_r     <= 1'b0;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  oe_n_r     <= SRAM_CTRL_IDLE;
                  ce_n_r     <= SRAM_CTRL_IDLE;
                  wait_cnt_r <= {WAIT_W{1'b0}};
                  state_r    <= ST_SHIFT;
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (bus.shift_en && last_s) begin
                  byte_done_r <= 1'b1;
                  busy_r      <= 1'b0;
                  addr_r      <= addr_r + ADDR_W'(1);
                  state_r     <= ST_IDLE;
               end else begin
                  busy_r      <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               wait_cnt_r  <= {WAIT_W{1'b0}};
               oe_n_r      <= SRAM_CTRL_IDLE;
               ce_n_r      <= SRAM_CTRL_IDLE;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sram_addr = addr_r;
   assign bus.sram_oe_n = oe_n_r;
   assign bus.sram_ce_n = ce_n_r;
   assign bus.avr_so    = so_s;
   assign bus.busy      = busy_r;
   assign bus.byte_done = byte_done_r;
endmodule

// File: tb/tb_sram_serial_reader.sv
// Directed bench for sram_serial_reader: SRAM model driven from the address,
// expected bytes queued at each request and compared when the byte completes.
module tb_sram_serial_reader;
   import qd2_pkg::*;

   localparam int AW = DEF_ADDR_W;
   localparam int DW = DEF_DATA_W;
   localparam int AC = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   bd_seen = 0;
   int   bd_exp  = 0;
   logic [DW-1:0] sb[$];
   logic [AW-1:0] addr_exp;
   logic [DW-1:0] got;

   always #5 clk = ~clk;

   sram_serial_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_serial_reader #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
      .avr_clk   (clk),
      .avr_reset (rst),
      .bus       (bus)
   );

   function automatic logic [DW-1:0] mem_byte(input logic [AW-1:0] a);
      if (a == 21'h000010) return 8'hA5;
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // SRAM drives valid data only while both strobes are active.
   always_comb begin
      if (!bus.sram_oe_n && !bus.sram_ce_n) bus.sram_data = mem_byte(bus.sram_addr);
      else bus.sram_data = {DW{1'bx}};
   end

   always @(negedge clk) if (bus.byte_done === 1'b1) bd_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_ok(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_oe_n"}, 32'(bus.sram_oe_n), 32'd1);
      chk({tag, "_ce_n"}, 32'(bus.sram_ce_n), 32'd1);
   endtask

   task automatic do_load(input logic [AW-1:0] a);
      bus.start_addr = a;
      bus.load = 1'b1;
      cyc();
      bus.load = 1'b0;
      addr_exp = a;
      chk("load_addr", 32'(bus.sram_addr), 32'(a));
   endtask

   task automatic start_read(input logic junk_shift);
      logic [DW-1:0] e;
      e = mem_byte(addr_exp);
      sb.push_back(e);
      bus.rd_req = 1'b1;
      bus.shift_en = junk_shift;
      cyc();
      bus.rd_req = 1'b0;
      chk("edge0_oe_n", 32'(bus.sram_oe_n), 32'd1);
      chk("edge0_busy", 32'(bus.busy), 32'd1);
      chk("edge0_byte_done", 32'(bus.byte_done), 32'd0);
      for (int i = 1; i <= AC; i++) begin
         cyc();
         chk("read_oe_n", 32'(bus.sram_oe_n), 32'd0);
         chk("read_ce_n", 32'(bus.sram_ce_n), 32'd0);
         chk("read_busy", 32'(bus.busy), 32'd1);
      end
      cyc();
      bus.shift_en = 1'b0;
      chk("cap_oe_n", 32'(bus.sram_oe_n), 32'd1);
      chk("cap_ce_n", 32'(bus.sram_ce_n), 32'd1);
      chk("cap_so", 32'(bus.avr_so), 32'(e[DW-1]));
      chk("cap_busy", 32'(bus.busy), 32'd1);
   endtask

   task automatic shift_bits(input int n, input logic rd_too);
      logic [DW-1:0] e;
      e = sb[0];
      for (int k = 0; k < n; k++) begin
         got = {got[DW-2:0], bus.avr_so};
         bus.shift_en = 1'b1;
         bus.rd_req = rd_too;
         cyc();
         bus.shift_en = 1'b0;
         bus.rd_req = 1'b0;
         if (k < DW - 1) begin
            chk("so_bit", 32'(bus.avr_so), 32'(e[DW-2-k]));
            chk("shift_busy", 32'(bus.busy), 32'd1);
            chk("shift_byte_done", 32'(bus.byte_done), 32'd0);
            cyc();
            chk("so_hold", 32'(bus.avr_so), 32'(e[DW-2-k]));
         end
      end
   endtask

   task automatic finish_read();
      logic [DW-1:0] e;
      addr_exp = addr_exp + AW'(1);
      chk("done_pulse", 32'(bus.byte_done), 32'd1);
      chk("done_busy", 32'(bus.busy), 32'd0);
      chk("done_so", 32'(bus.avr_so), 32'd0);
      chk("done_addr", 32'(bus.sram_addr), 32'(addr_exp));
      chk("sb_size", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("sb_byte", 32'(got), 32'(e));
      end
      bd_exp++;
   endtask

   task automatic full_read(input logic junk_shift, input logic rd_too);
      start_read(junk_shift);
      got = '0;
      shift_bits(DW, rd_too);
      finish_read();
   endtask

   initial begin
      rst = 1'b1;
      bus.start_addr = '0;
      bus.load = 1'b0;
      bus.rd_req = 1'b0;
      bus.shift_en = 1'b0;
      addr_exp = '0;
      got = '0;
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_addr", 32'(bus.sram_addr), 32'd0);
      chk("rst_so", 32'(bus.avr_so), 32'd0);
      chk("rst_byte_done", 32'(bus.byte_done), 32'd0);
      idle_ok("rst");

      // 0xA5 at 0x10 with shift_en asserted during READ, then a back-to-back read
      do_load(21'h000010);
      full_read(1'b1, 1'b0);
      chk("a5_bits", 32'(got), 32'h0000_00A5);
      full_read(1'b0, 1'b0);
      cyc();
      chk("pulse_one_cycle", 32'(bus.byte_done), 32'd0);
      idle_ok("after_b2b");

      // reset in the middle of SHIFT
      do_load(21'h000040);
      start_read(1'b0);
      got = '0;
      shift_bits(3, 1'b0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      sb.delete();
      addr_exp = '0;
      chk("midrst_addr", 32'(bus.sram_addr), 32'd0);
      chk("midrst_so", 32'(bus.avr_so), 32'd0);
      idle_ok("midrst");

      // address wraps at the top of the space
      do_load(21'h1FFFFF);
      full_read(1'b0, 1'b0);
      chk("wrap_addr", 32'(bus.sram_addr), 32'd0);
      cyc();

      // abort by load after 4 bits
      start_read(1'b0);
      got = '0;
      shift_bits(4, 1'b0);
      bus.start_addr = 21'h000100;
      bus.load = 1'b1;
      cyc();
      bus.load = 1'b0;
      void'(sb.pop_back());
      addr_exp = 21'h000100;
      chk("abort_addr", 32'(bus.sram_addr), 32'h100);
      chk("abort_byte_done", 32'(bus.byte_done), 32'd0);
      idle_ok("abort");
      cyc();
      chk("abort_no_done", 32'(bus.byte_done), 32'd0);
      full_read(1'b0, 1'b0);
      cyc();

      // load wins over rd_req in the same cycle
      bus.start_addr = 21'h000020;
      bus.load = 1'b1;
      bus.rd_req = 1'b1;
      cyc();
      bus.load = 1'b0;
      bus.rd_req = 1'b0;
      addr_exp = 21'h000020;
      chk("ldrd_addr", 32'(bus.sram_addr), 32'h20);
      idle_ok("ldrd0");
      cyc();
      idle_ok("ldrd1");

      // rd_req while busy is dropped
      full_read(1'b0, 1'b1);
      cyc();
      idle_ok("busy_rd0");
      cyc();
      idle_ok("busy_rd1");
      cyc();
      chk("byte_done_count", 32'(bd_seen), 32'(bd_exp));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_serial_reader.md
# sram_serial_reader

Serial read-back path from SRAM to the AVR, the counterpart of the serial address-load shift register that lets the AVR write the SRAM address into the CPLD. Given a start address, the block fetches one SRAM byte per request and shifts it out MSB-first on a single line, one bit per AVR shift strobe. It then auto-increments the address. It sits in the CPLD next to the bus FSM, sharing the SRAM address and control lines under AVR mode.

## Interface

Parameters:
- ADDR_W, 21, SRAM address width
- DATA_W, 8, data byte width (bit counter sized to it)
- ACCESS_CYCLES, 2, clock cycles `oe_n`/`ce_n` are held low before data capture (≥1)

Ports:
- avr_clk  in  1  system clock; all logic on rising edge
- avr_reset  in  1  synchronous, active-high reset
- start_addr  in  ADDR_W  start address, parallel (from address shift register)
- load  in  1  one-cycle strobe: latch `start_addr` into address counter
- rd_req  in  1  one-cycle strobe: fetch byte at current address
- shift_en  in  1  one-cycle strobe: advance serial output by one bit
- sram_data  in  DATA_W  SRAM read data
- sram_addr  out  ADDR_W  SRAM address (= address counter)
- sram_oe_n  out  1  SRAM output enable, active low
- sram_ce_n  out  1  SRAM chip enable, active low
- avr_so  out  1  serial data to AVR
- busy  out  1  high in READ and SHIFT
- byte_done  out  1  one-cycle pulse after last bit shifted

## Operation

- States:
  - IDLE
    - `load` → latch address, stay IDLE.
    - `rd_req` → READ.
  - READ
    - `sram_oe_n`, `sram_ce_n` low.
    - Wait counter runs 0..ACCESS_CYCLES-1.
    - On last count: capture `sram_data` into shift register, clear bit counter → SHIFT.
  - SHIFT
    - `avr_so` = shift register MSB.
    - Each `shift_en`: shift left, zero fill; bit counter +1.
    - On DATA_W-th `shift_en`: pulse `byte_done`, increment address → IDLE.
- Address increment wraps from 2^ADDR_W−1 to 0.
- `load` in READ or SHIFT: abort.
  - Latch new address, → IDLE.
  - `oe_n`/`ce_n` high next cycle, no `byte_done`, no increment.
- `load` and `rd_req` in the same IDLE cycle: `load` wins, `rd_req` dropped.
- `rd_req` while busy: ignored.
- `shift_en` outside SHIFT: ignored.
- Reset values:
  - `sram_addr` = 0
  - `sram_oe_n` = 1, `sram_ce_n` = 1
  - `avr_so` = 0, `busy` = 0, `byte_done` = 0
  - State IDLE, counters 0.
- Reset overrides everything, including mid-READ/SHIFT.

## Timing

- Registered outputs only; no combinational path from inputs to outputs.
- `rd_req` sampled at edge 0:
  - Edges 1..ACCESS_CYCLES: `oe_n`/`ce_n` low, `busy` high.
  - Data captured at edge ACCESS_CYCLES+1. From there: state SHIFT, `oe_n`/`ce_n` high, `avr_so` = bit 7.
- Bit k of the byte (after k `shift_en`) is valid on `avr_so` the cycle after the k-th strobe.
- The edge sampling the 8th `shift_en`:
  - Sets `byte_done` = 1 for one cycle.
  - Sets `busy` = 0.
  - Sets `sram_addr` = old+1.
  - Sets `avr_so` = 0.
- Next `rd_req` is accepted the cycle `byte_done` is high (state already IDLE).
- `load` takes effect on `sram_addr` one cycle after the strobe.

## Structure

- Shared package `qd2_pkg`:
  - ADDR_W, DATA_W constants.
  - State enum (IDLE, READ, SHIFT).
  - Reset values for SRAM control lines.
- One sub-module: `piso_shift`, a parallel-in/serial-out register.
  - Ports: load, shift, DATA_W width, bit counter, `last` flag.
- FSM, wait counter and address counter stay in the top module.

## Test plan

- Reset mid-SHIFT (after 3 `shift_en`) → next cycle `busy`=0, `oe_n`=`ce_n`=1, `avr_so`=0, `sram_addr`=0.
- `load` 0x00010, `rd_req`, SRAM returns 0xA5, 8× `shift_en` → `avr_so` sequence 1,0,1,0,0,1,0,1. Then `byte_done` pulse, `sram_addr`=0x00011.
- ACCESS_CYCLES=2: `rd_req` at edge 0 → `oe_n` low exactly edges 1–2. Capture at edge 3. `shift_en` during READ has no effect.
- `load` 0x1FFFFF, read + 8 shifts → `sram_addr` wraps to 0x000000.
- `load` 0x00100 during SHIFT after 4 bits → IDLE next cycle, no `byte_done`, `sram_addr`=0x00100. `rd_req` then reads 0x00100.
- `load` 0x00020 and `rd_req` in the same cycle → no READ, `sram_addr`=0x00020. `rd_req` while busy is ignored; only one `byte_done` per accepted request.
